// File: rtl/ft245_device_emu.sv
// FTDI-side emulator of the FT245 asynchronous FIFO bus: answers RD#/WR# strobes from an
// FPGA controller and bridges each direction to a host-side ready/valid byte FIFO.
module ft245_device_emu #(
    parameter int DEPTH_LOG2   = 4,
    parameter int RD_DELAY     = 2,
    parameter int RXF_INACTIVE = 4,
    parameter int TXE_INACTIVE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in_245,
    output logic [7:0] data_out_245,
    output logic       data_oe_245,
    output logic       rxf_245,
    input  logic       rx_245,
    output logic       txe_245,
    input  logic       wr_245,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    input  logic       host_rx_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int CW    = 8;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_RECOVER} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RECOVER} wr_state_t;

    // ---------------- strobe / data synchronizers ----------------
    logic       r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2;
    logic [7:0] r_din_s1, r_din_s2;
    logic [1:0] r_warm;
    logic       r_rd_arm, r_wr_arm;
    logic       w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;

    // A strobe must be seen high by a real (post-reset) sample before its fall counts,
    // so a strobe held low across reset cannot start a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_s1  <= 1'b1;
            r_rd_s2  <= 1'b1;
            r_wr_s1  <= 1'b1;
            r_wr_s2  <= 1'b1;
            r_din_s1 <= '0;
            r_din_s2 <= '0;
            r_warm   <= '0;
            r_rd_arm <= 1'b0;
            r_wr_arm <= 1'b0;
        end else begin
            r_rd_s1  <= rx_245;
            r_rd_s2  <= r_rd_s1;
            r_wr_s1  <= wr_245;
            r_wr_s2  <= r_wr_s1;
            r_din_s1 <= data_in_245;
            r_din_s2 <= r_din_s1;
            r_warm   <= {r_warm[0], 1'b1};
            r_rd_arm <= r_rd_arm | (r_warm[1] & r_rd_s2);
            r_wr_arm <= r_wr_arm | (r_warm[1] & r_wr_s2);
        end
    end

    assign w_rd_fall = r_rd_arm & r_rd_s2 & ~r_rd_s1;
    assign w_rd_rise = ~r_rd_s2 & r_rd_s1;
    assign w_wr_fall = r_wr_arm & r_wr_s2 & ~r_wr_s1;
    assign w_wr_rise = ~r_wr_s2 & r_wr_s1;

    // ---------------- RX FIFO (host -> FPGA) ----------------
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
    logic [7:0]    w_rx_head;

    assign w_rx_empty    = (r_rx_wr_ptr == r_rx_rd_ptr);
    assign w_rx_full     = (r_rx_wr_ptr[PW-1] != r_rx_rd_ptr[PW-1]) &&
                           (r_rx_wr_ptr[PW-2:0] == r_rx_rd_ptr[PW-2:0]);
    assign host_tx_ready = ~rst & ~w_rx_full;
    assign w_rx_push     = host_tx_valid & host_tx_ready;
    assign w_rx_head     = r_rx_mem[r_rx_rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wr_ptr[PW-2:0]] <= host_tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FIFO (FPGA -> host) ----------------
    logic [7:0]    r_tx_mem [DEPTH];
    logic [PW-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

    assign w_tx_empty    = (r_tx_wr_ptr == r_tx_rd_ptr);
    assign w_tx_full     = (r_tx_wr_ptr[PW-1] != r_tx_rd_ptr[PW-1]) &&
                           (r_tx_wr_ptr[PW-2:0] == r_tx_rd_ptr[PW-2:0]);
    assign host_rx_valid = ~w_tx_empty;
    assign host_rx_data  = r_tx_mem[r_tx_rd_ptr[PW-2:0]];
    assign w_tx_pop      = host_rx_valid & host_rx_ready;

    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wr_ptr[PW-2:0]] <= r_din_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
        end
    end

    // ---------------- read FSM (RD# / RXF#) ----------------
    rd_state_t       r_rd_state;
    logic [CW-1:0]   r_rd_cnt;
    logic            r_rxf, r_oe;
    logic [7:0]      r_dout;

    assign w_rx_pop = (r_rd_state == R_DRIVE) & w_rd_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= '0;
            r_rxf      <= 1'b1;
            r_oe       <= 1'b0;
            r_dout     <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    r_rxf <= w_rx_empty;
                    // A fall on an empty FIFO is an underrun: leave the bus alone.
                    if (w_rd_fall && !w_rx_empty) begin
                        r_rd_state <= R_WAIT;
                        r_rd_cnt   <= CW'(RD_DELAY - 1);
                    end
                end
                R_WAIT: begin
                    if (w_rd_rise) begin
                        r_rd_state <= R_RECOVER;
                        r_rd_cnt   <= CW'(RXF_INACTIVE - 1);
                        r_rxf      <= 1'b1;
                    end else if (r_rd_cnt == '0) begin
                        r_rd_state <= R_DRIVE;
                        r_oe       <= 1'b1;
                        r_dout     <= w_rx_head;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                end
                R_DRIVE: begin
                    if (w_rd_rise) begin
                        r_rd_state <= R_RECOVER;
                        r_rd_cnt   <= CW'(RXF_INACTIVE - 1);
                        r_oe       <= 1'b0;
                        r_rxf      <= 1'b1;
                    end
                end
                R_RECOVER: begin
                    if (r_rd_cnt == '0) begin
                        r_rd_state <= R_IDLE;
                        r_rxf      <= w_rx_empty;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                        r_rxf    <= 1'b1;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign rxf_245      = r_rxf;
    assign data_oe_245  = r_oe;
    assign data_out_245 = r_dout;

    // ---------------- write FSM (WR# / TXE#) ----------------
    wr_state_t     r_wr_state;
    logic [CW-1:0] r_wr_cnt;
    logic          r_txe;

    // A write against a full FIFO still completes the handshake; the byte is dropped.
    assign w_tx_push = (r_wr_state == W_ACTIVE) & w_wr_rise & ~w_tx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= '0;
            r_txe      <= 1'b1;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    r_txe <= w_tx_full;
                    if (w_wr_fall)
                        r_wr_state <= W_ACTIVE;
                end
                W_ACTIVE: begin
                    if (w_wr_rise) begin
                        r_wr_state <= W_RECOVER;
                        r_wr_cnt   <= CW'(TXE_INACTIVE - 1);
                        r_txe      <= 1'b1;
                    end
                end
                W_RECOVER: begin
                    if (r_wr_cnt == '0) begin
                        r_wr_state <= W_IDLE;
                        r_txe      <= w_tx_full;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 1'b1;
                        r_txe    <= 1'b1;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign txe_245 = r_txe;

endmodule

// File: tb/tb_ft245_device_emu.sv
// Directed bench for ft245_device_emu: FT245 read/write handshakes, FIFO full/wrap,
// overflow drop and reset during an active read.
module tb_ft245_device_emu;
    localparam int RD_DELAY     = 2;
    localparam int RXF_INACTIVE = 4;
    localparam int TXE_INACTIVE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in_245 = '0;
    logic [7:0] data_out_245;
    logic       data_oe_245;
    logic       rxf_245;
    logic       rx_245 = 1'b1;
    logic       txe_245;
    logic       wr_245 = 1'b1;
    logic [7:0] host_tx_data = '0;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ft245_device_emu #(
        .DEPTH_LOG2  (4),
        .RD_DELAY    (RD_DELAY),
        .RXF_INACTIVE(RXF_INACTIVE),
        .TXE_INACTIVE(TXE_INACTIVE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_245  (data_in_245),
        .data_out_245 (data_out_245),
        .data_oe_245  (data_oe_245),
        .rxf_245      (rxf_245),
        .rx_245       (rx_245),
        .txe_245      (txe_245),
        .wr_245       (wr_245),
        .host_tx_data (host_tx_data),
        .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready),
        .host_rx_data (host_rx_data),
        .host_rx_valid(host_rx_valid),
        .host_rx_ready(host_rx_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RD# pulse: bus must be driven exactly RD_DELAY+2 cycles after the fall.
    // Returns on the cycle the read FSM is back in idle.
    task automatic do_read(input logic [7:0] exp, input string tag);
        rx_245 = 1'b0;
        repeat (RD_DELAY + 1) step();
        chk1({tag, "_oe_early"}, data_oe_245, 1'b0);
        step();
        chk1({tag, "_oe"}, data_oe_245, 1'b1);
        chk8({tag, "_data"}, data_out_245, exp);
        rx_245 = 1'b1;
        step();
        step();
        chk1({tag, "_oe_release"}, data_oe_245, 1'b0);
        chk1({tag, "_rxf_recover"}, rxf_245, 1'b1);
        repeat (RXF_INACTIVE - 1) step();
        chk1({tag, "_rxf_hold"}, rxf_245, 1'b1);
        step();
    endtask

    // WR# pulse with a steady byte on the bus; TXE# must be high for TXE_INACTIVE cycles.
    task automatic do_write(input logic [7:0] d, input string tag);
        data_in_245 = d;
        wr_245 = 1'b0;
        repeat (3) step();
        wr_245 = 1'b1;
        step();
        step();
        chk1({tag, "_txe_recover"}, txe_245, 1'b1);
        repeat (TXE_INACTIVE - 1) step();
        chk1({tag, "_txe_hold"}, txe_245, 1'b1);
        step();
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk1("rst_rxf", rxf_245, 1'b1);
        chk1("rst_txe", txe_245, 1'b1);
        chk1("rst_oe", data_oe_245, 1'b0);
        chk8("rst_dout", data_out_245, 8'h00);
        chk1("rst_tx_ready", host_tx_ready, 1'b0);
        chk1("rst_rx_valid", host_rx_valid, 1'b0);

        rst = 1'b0;
        repeat (4) step();
        chk1("idle_rxf", rxf_245, 1'b1);
        chk1("idle_txe", txe_245, 1'b0);
        chk1("idle_oe", data_oe_245, 1'b0);
        chk1("idle_rx_valid", host_rx_valid, 1'b0);
        chk1("idle_tx_ready", host_tx_ready, 1'b1);

        // RD# on an empty FIFO is ignored
        rx_245 = 1'b0;
        repeat (6) step();
        chk1("underrun_oe", data_oe_245, 1'b0);
        rx_245 = 1'b1;
        repeat (6) step();
        chk1("underrun_rxf", rxf_245, 1'b1);

        // Single byte host -> FPGA
        host_tx_data  = 8'hA5;
        host_tx_valid = 1'b1;
        step();
        host_tx_valid = 1'b0;
        step();
        chk1("a5_rxf_low", rxf_245, 1'b0);
        do_read(8'hA5, "a5");
        chk1("a5_rxf_empty", rxf_245, 1'b1);
        repeat (3) step();
        chk1("a5_rxf_stays", rxf_245, 1'b1);

        // Fill RX FIFO with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            host_tx_data  = 8'(i);
            host_tx_valid = 1'b1;
            if (i == 15) chk1("fill_ready_before_last", host_tx_ready, 1'b1);
            step();
        end
        chk1("fill_full", host_tx_ready, 1'b0);
        host_tx_data = 8'h10;
        step();
        chk1("fill_still_full", host_tx_ready, 1'b0);
        do_read(8'h00, "rd00");
        chk1("push17_accepted", host_tx_ready, 1'b0);
        chk1("rd00_rxf", rxf_245, 1'b0);
        host_tx_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            do_read(8'(i), "rdn");
            chk1("rdn_rxf", rxf_245, 1'b0);
        end
        do_read(8'h10, "rd10");
        chk1("drained_rxf", rxf_245, 1'b1);
        chk1("drained_ready", host_tx_ready, 1'b1);

        // Single byte FPGA -> host
        chk1("w3c_txe_before", txe_245, 1'b0);
        do_write(8'h3C, "w3c");
        chk1("w3c_txe_low", txe_245, 1'b0);
        chk1("w3c_valid", host_rx_valid, 1'b1);
        chk8("w3c_data", host_rx_data, 8'h3C);
        host_rx_ready = 1'b1;
        step();
        host_rx_ready = 1'b0;
        chk1("w3c_popped", host_rx_valid, 1'b0);

        // 17 writes into a 16-deep TX FIFO: last byte dropped
        for (int i = 0; i < 17; i++) begin
            do_write(8'(8'h40 + i), "wfill");
            if (i == 14) chk1("wfill_txe_not_full", txe_245, 1'b0);
            if (i >= 15) chk1("wfill_txe_full", txe_245, 1'b1);
        end
        host_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk1("drain_valid", host_rx_valid, 1'b1);
            chk8("drain_data", host_rx_data, 8'(8'h40 + i));
            step();
        end
        chk1("drain_empty", host_rx_valid, 1'b0);
        host_rx_ready = 1'b0;
        step();
        chk1("drain_txe_low", txe_245, 1'b0);

        // Reset during R_DRIVE
        host_tx_data  = 8'h77;
        host_tx_valid = 1'b1;
        step();
        host_tx_valid = 1'b0;
        step();
        rx_245 = 1'b0;
        repeat (RD_DELAY + 2) step();
        chk1("mid_oe", data_oe_245, 1'b1);
        chk8("mid_data", data_out_245, 8'h77);
        rst = 1'b1;
        #1;
        chk1("mid_rst_oe", data_oe_245, 1'b0);
        chk1("mid_rst_rxf", rxf_245, 1'b1);
        chk1("mid_rst_ready", host_tx_ready, 1'b0);
        step();
        step();
        host_tx_data  = 8'h99;
        host_tx_valid = 1'b1;
        rst = 1'b0;
        step();
        host_tx_valid = 1'b0;
        repeat (8) step();
        chk1("held_low_no_read", data_oe_245, 1'b0);
        chk1("held_low_rxf", rxf_245, 1'b0);
        rx_245 = 1'b1;
        repeat (3) step();
        do_read(8'h99, "rd99");
        chk1("rd99_rxf", rxf_245, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ft245_device_emu.md
Name: ft245_device_emu

Overview:
- Synthesizable emulator of the FTDI-chip end of the FT245 asynchronous FIFO interface. The FPGA FT245 controller connects to it in loopback or on-target test builds.
- The block drives rxf_245/txe_245 and the data bus, and responds to rx_245 (RD#) and wr_245 (WR#) strobes.
- Two internal byte FIFOs sit behind a ready/valid "host" interface:
  - RX FIFO: host to FPGA.
  - TX FIFO: FPGA to host.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).
- RD_DELAY, 2, clk cycles from detected RD# fall to data valid on bus.
- RXF_INACTIVE, 4, clk cycles rxf_245 held high after each RD# rise.
- TXE_INACTIVE, 4, clk cycles txe_245 held high after each WR# rise.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- data_in_245  in  8  bus value driven by FPGA controller.
- data_out_245  out  8  bus value driven by emulator during read.
- data_oe_245  out  1  emulator bus drive enable.
- rxf_245  out  1  RXF#, low = byte available for FPGA.
- rx_245  in  1  RD# from FPGA controller, active-low.
- txe_245  out  1  TXE#, low = FPGA may write.
- wr_245  in  1  WR# from FPGA controller, active-low.
- host_tx_data  in  8  byte to push into RX FIFO.
- host_tx_valid  in  1  host byte valid.
- host_tx_ready  out  1  RX FIFO not full.
- host_rx_data  out  8  head of TX FIFO.
- host_rx_valid  out  1  TX FIFO not empty.
- host_rx_ready  in  1  host consumes head byte.

Behaviour:
- Reset values:
  - rxf_245=1, txe_245=1, data_oe_245=0, data_out_245=0.
  - host_tx_ready=0 during reset, then 1.
  - host_rx_valid=0; both FIFOs empty; all counters 0.
- Strobe inputs:
  - rx_245 and wr_245 pass through 2-flop synchronizers (reset to 1).
  - Fall and rise edges are detected on the synchronized value.
  - Reaction latency is counted from the edge-detect cycle.
- FIFOs:
  - Circular buffers, pointers DEPTH_LOG2+1 bits wide.
  - Full when MSBs differ and LSBs are equal; empty when pointers are equal.
  - Wrap-around is natural modulo 2^(DEPTH_LOG2+1).
- Host push: host_tx_valid&host_tx_ready writes the RX FIFO on that edge.
- Host pop: host_rx_valid&host_rx_ready pops the TX FIFO.
  - host_rx_data is the combinational head of the TX FIFO.
- Read FSM states: R_IDLE, R_WAIT, R_DRIVE, R_RECOVER.
  - R_IDLE: rxf_245 = RX FIFO empty.
    - RD# fall with FIFO non-empty -> R_WAIT, counter=RD_DELAY-1.
    - RD# fall with FIFO empty is ignored: bus not driven, no pop; flag read_underrun not exported.
  - R_WAIT: count to 0 -> R_DRIVE.
    - Entering R_DRIVE sets data_oe_245=1 and data_out_245=RX FIFO head.
  - R_DRIVE: hold until RD# rise.
    - On rise: data_oe_245=0, pop RX FIFO, rxf_245=1 -> R_RECOVER.
    - RD# rise during R_WAIT aborts: no pop, oe stays 0 -> R_RECOVER.
  - R_RECOVER: rxf_245 held 1 for RXF_INACTIVE cycles -> R_IDLE.
- Write FSM states: W_IDLE, W_ACTIVE, W_RECOVER.
  - W_IDLE: txe_245 = TX FIFO full.
    - WR# fall -> W_ACTIVE.
  - W_ACTIVE: on WR# rise, capture synchronized data_in_245 delayed 2 cycles, aligned with the strobe.
    - If TX FIFO not full: push the byte.
    - Then txe_245=1 -> W_RECOVER.
    - WR# fall while txe_245=1 (FIFO full) is still tracked, but the byte is dropped (overflow, no push).
  - W_RECOVER: txe_245 held 1 for TXE_INACTIVE cycles -> W_IDLE.
- Simultaneous events:
  - Host push and RX pop in the same cycle are both honoured; count unchanged.
  - Host pop and TX push in the same cycle are both honoured.
  - Concurrent RD# and WR# activity is handled independently; the FPGA controller never asserts both at once.
- Reset asserted mid-transfer:
  - Immediately releases the bus (data_oe_245=0) and empties both FIFOs.
  - FSMs go to idle; strobes must be observed high before a new fall is accepted.

Test Plan:
- Reset release, no host traffic -> rxf_245=1, txe_245=0, data_oe_245=0, host_rx_valid=0.
- Host pushes 0xA5: rxf_245 falls next cycle. RD# low -> data_oe_245=1 with data_out_245=0xA5, exactly RD_DELAY+2 cycles after the RD# fall. RD# high -> rxf_245=1 for 4 cycles, then stays 1 (FIFO empty).
- Host pushes 0x00..0x0F without FPGA reads -> host_tx_ready=0 after the 16th byte. 16 reads return 0x00..0x0F in order; pointers wrap cleanly; a 17th push is accepted after the first read.
- FPGA writes 0x3C via WR# pulse with data_in_245=0x3C -> host_rx_valid=1, host_rx_data=0x3C. txe_245 high for 4 cycles after WR# rise, then low.
- FPGA writes 17 bytes with host_rx_ready=0 -> txe_245 stays 1 once 16 stored. 17th byte dropped; the host drains exactly 16 bytes in order.
- Assert rst while R_DRIVE is active -> data_oe_245=0 in the same cycle, rxf_245=1. After release, a held-low RD# does not produce a read until it goes high and falls again.
